// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states and
// the default lui shift amount.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int unsigned LUI_SHAMT_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU: and/or/add/sub/slt with signed overflow for
// add and sub.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sum_ovf;
  logic             diff_ovf;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  assign sum_ovf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign diff_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (alu_ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = sum_ovf;
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = diff_ovf;
      end
      // True signed compare; the sign of diff is wrong when diff overflows.
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage unit: one-cycle ALU ops and bit-serial shifts (sra/srav/lui)
// behind valid/ready handshakes on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LUI_SHAMT = LUI_SHAMT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       shamt_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic             result_sel_i,
  input  logic             left_right_i,
  input  logic             shift_src_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam logic [4:0] LuiAmt = 5'(LUI_SHAMT);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] shifted;
  logic [4:0]       shift_amt;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .a_i       (src1_i),
    .b_i       (src2_i),
    .alu_ctrl_i(alu_ctrl_i),
    .result_o  (alu_res),
    .overflow_o(alu_ovf)
  );

  // result_q doubles as the shift working register while in StShift.
  assign shifted = dir_q ? {result_q[WIDTH-1], result_q[WIDTH-1:1]}
                         : {result_q[WIDTH-2:0], 1'b0};

  assign shift_amt = shift_src_i  ? src1_i[4:0] :
                     left_right_i ? shamt_i     : LuiAmt;

  assign ready_o    = (state_q == StIdle);
  assign valid_o    = (state_q == StDone);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    case (state_q)
      StIdle: begin
        if (valid_i) begin
          if (!result_sel_i) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            state_d  = StDone;
          end else begin
            result_d = src2_i;
            zero_d   = (src2_i == '0);
            ovf_d    = 1'b0;
            dir_d    = left_right_i;
            cnt_d    = shift_amt;
            state_d  = (shift_amt == 5'd0) ? StDone : StShift;
          end
        end
      end
      StShift: begin
        result_d = shifted;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          zero_d  = (shifted == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= 5'd0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, random ops
// against a behavioural model, back-pressure and mid-shift reset sequences.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [3:0]  alu_ctrl_i;
  logic        result_sel_i;
  logic        left_right_i;
  logic        shift_src_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;
  logic        valid_o;
  logic        ready_i;

  int tests = 0;
  int fails = 0;

  localparam longint MaxS = 64'sh7FFF_FFFF;
  localparam longint MinS = -64'sh8000_0000;

  always #5 clk_i = ~clk_i;

  alu_exec_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .shamt_i     (shamt_i),
    .alu_ctrl_i  (alu_ctrl_i),
    .result_sel_i(result_sel_i),
    .left_right_i(left_right_i),
    .shift_src_i (shift_src_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  typedef struct {
    string       name;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  shamt;
    logic [3:0]  ctrl;
    logic        sel;
    logic        lr;
    logic        ss;
    logic [31:0] exp;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written from the operation semantics with wide arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [3:0] ctrl,
                                input logic sel, input logic lr, input logic ss,
                                output logic [31:0] r, output logic o, output int lat);
    longint s;
    int     amt;
    r   = 32'h0;
    o   = 1'b0;
    lat = 1;
    if (!sel) begin
      case (ctrl)
        4'b0000: r = a & b;
        4'b0001: r = a | b;
        4'b0010: begin
          s = longint'($signed(a)) + longint'($signed(b));
          r = s[31:0];
          o = (s > MaxS) || (s < MinS);
        end
        4'b0110: begin
          s = longint'($signed(a)) - longint'($signed(b));
          r = s[31:0];
          o = (s > MaxS) || (s < MinS);
        end
        4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = 32'h0;
      endcase
    end else begin
      amt = ss ? int'(a[4:0]) : (lr ? int'(sh) : 16);
      r   = lr ? 32'($signed(b) >>> amt) : (b << amt);
      lat = 1 + amt;
    end
  endfunction

  task automatic run_op(input string name, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [4:0] sh, input logic [3:0] ctrl, input logic sel,
                        input logic lr, input logic ss, input logic [31:0] exp,
                        input logic ovf, input int exp_lat);
    int lat;
    int waitc;
    @(negedge clk_i);
    waitc = 0;
    while (!ready_o && waitc < 50) begin
      @(negedge clk_i);
      waitc++;
    end
    check({name, " ready"}, {31'd0, ready_o}, 32'd1);
    src1_i       = s1;
    src2_i       = s2;
    shamt_i      = sh;
    alu_ctrl_i   = ctrl;
    result_sel_i = sel;
    left_right_i = lr;
    shift_src_i  = ss;
    valid_i      = 1'b1;
    @(posedge clk_i);
    lat = 0;
    forever begin
      #1;
      valid_i = 1'b0;
      lat++;
      if (valid_o || lat > 40) break;
      @(posedge clk_i);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result_o, exp);
    check({name, " zero"}, {31'd0, zero_o}, {31'd0, exp == 32'h0});
    check({name, " overflow"}, {31'd0, overflow_o}, {31'd0, ovf});
    @(posedge clk_i);
    #1;
    check({name, " valid drop"}, {31'd0, valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic        o;
    int          lat;
    logic [3:0]  ctrl;
    logic        sel;
    logic [31:0] edges[5];

    vecs[0]  = '{"add ovf",     32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1};
    vecs[1]  = '{"sub zero",    32'd5,         32'd5,         5'd0, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1};
    vecs[2]  = '{"slt neg",     32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 4'b0111, 1'b0, 1'b0, 1'b0, 32'd1,         1'b0, 1};
    vecs[3]  = '{"slt wrap",    32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 4'b0111, 1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 1};
    vecs[4]  = '{"and",         32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00F0_00F0, 1'b0, 1};
    vecs[5]  = '{"or",          32'h1200_0034, 32'h0034_1200, 5'd0, 4'b0001, 1'b0, 1'b0, 1'b0, 32'h1234_1234, 1'b0, 1};
    vecs[6]  = '{"undef op",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 4'b1111, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1};
    vecs[7]  = '{"sub ovf",     32'h8000_0000, 32'h0000_0001, 5'd0, 4'b0110, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[8]  = '{"sra 4",       32'h0,         32'hF000_0000, 5'd4, 4'b0000, 1'b1, 1'b1, 1'b0, 32'hFF00_0000, 1'b0, 5};
    vecs[9]  = '{"srav 3",      32'h23,        32'h0000_0040, 5'd0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 4};
    vecs[10] = '{"lui",         32'h0,         32'h0000_1234, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h1234_0000, 1'b0, 17};
    vecs[11] = '{"srav 0",      32'h20,        32'hDEAD_BEEF, 5'd7, 4'b0000, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[12] = '{"sllv to 0",   32'h1,         32'h8000_0000, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 2};

    edges[0] = 32'h7FFF_FFFF;
    edges[1] = 32'h8000_0000;
    edges[2] = 32'h0;
    edges[3] = 32'hFFFF_FFFF;
    edges[4] = 32'h1;

    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    src1_i = '0; src2_i = '0; shamt_i = '0; alu_ctrl_i = '0;
    result_sel_i = 1'b0; left_right_i = 1'b0; shift_src_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset result", result_o, 32'h0);
    check("reset valid", {31'd0, valid_o}, 32'd0);
    check("reset zero", {31'd0, zero_o}, 32'd0);
    check("reset ovf", {31'd0, overflow_o}, 32'd0);
    check("reset ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].s1, vecs[i].s2, vecs[i].shamt, vecs[i].ctrl, vecs[i].sel,
             vecs[i].lr, vecs[i].ss, vecs[i].exp, vecs[i].ovf, vecs[i].lat);

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 5))
        0: ctrl = 4'b0000;
        1: ctrl = 4'b0001;
        2: ctrl = 4'b0010;
        3: ctrl = 4'b0110;
        4: ctrl = 4'b0111;
        default: ctrl = 4'($urandom);
      endcase
      sel = ($urandom_range(0, 2) == 0);
      shamt_i = 5'($urandom);
      begin
        logic [4:0] sh;
        logic       lr, ss;
        sh = 5'($urandom);
        lr = 1'($urandom);
        ss = 1'($urandom);
        model(a, b, sh, ctrl, sel, lr, ss, r, o, lat);
        run_op($sformatf("rand%0d", i), a, b, sh, ctrl, sel, lr, ss, r, o, lat);
      end
    end

    // Back-pressure: result held in DONE while ready_i is low.
    ready_i = 1'b0;
    @(negedge clk_i);
    src1_i = 32'd3; src2_i = 32'd4; alu_ctrl_i = 4'b0010;
    result_sel_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    src1_i = 32'd100; src2_i = 32'd200;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      check("bp valid", {31'd0, valid_o}, 32'd1);
      check("bp result", result_o, 32'd7);
      check("bp ready", {31'd0, ready_o}, 32'd0);
    end
    @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("bp release valid", {31'd0, valid_o}, 32'd0);
    check("bp release ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    check("bp no accept", {31'd0, valid_o}, 32'd0);

    // Reset during a 10-bit sra aborts it.
    @(negedge clk_i);
    src1_i = 32'h0; src2_i = 32'h8000_0000; shamt_i = 5'd10;
    result_sel_i = 1'b1; left_right_i = 1'b1; shift_src_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    check("mid rst result", result_o, 32'h0);
    check("mid rst valid", {31'd0, valid_o}, 32'd0);
    check("mid rst zero", {31'd0, zero_o}, 32'd0);
    check("mid rst ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op("post rst add", 32'd10, 32'd20, 5'd0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'd30, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
